// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//   Multi-ported register file for the CPU datapath. Decode reads operands and
//   allocates destinations; writeback retires results through the write ports.
//
//   Features:
//     - NUM_RD combinational read ports, NUM_WR synchronous write ports
//     - optional same-cycle write-to-read bypass (BYPASS)
//     - optional hardwired-zero register 0 (ZERO_REG)
//     - per-register busy scoreboard (set by alloc, cleared by write)
//     - registered one-cycle pulse flagging colliding write addresses
//
//   Ports:
//     clk          clock, all state updates on the rising edge
//     rst          asynchronous active-low reset
//     ra           packed read addresses, port i at [i*ADDR_SIZE +: ADDR_SIZE]
//     rd           packed read data, port i at [i*WIDTH +: WIDTH]
//     rd_busy      busy flag of the register addressed by each read port
//     wa, wd, we   packed write addresses / data / enables
//     alloc_en     mark alloc_addr busy on the next rising edge
//     alloc_addr   register to mark busy
//     wr_conflict  pulse: two or more enabled writes hit one address last cycle
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int ADDR_SIZE = $clog2(DEPTH),
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 2,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*ADDR_SIZE-1:0] ra,
    output logic [NUM_RD*WIDTH-1:0]     rd,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic [NUM_WR*ADDR_SIZE-1:0] wa,
    input  logic [NUM_WR*WIDTH-1:0]     wd,
    input  logic [NUM_WR-1:0]           we,
    input  logic                        alloc_en,
    input  logic [ADDR_SIZE-1:0]        alloc_addr,
    output logic                        wr_conflict
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(DEPTH);

    logic [WIDTH-1:0]     r_regs [DEPTH];
    logic [DEPTH-1:0]     r_busy;
    logic                 r_wrConflict;

    logic [ADDR_SIZE-1:0] w_wrAddr [NUM_WR];
    logic [WIDTH-1:0]     w_wrData [NUM_WR];
    logic [NUM_WR-1:0]    w_wrValid;
    logic                 w_allocValid;
    logic                 w_conflict;

    // An address names real storage only if it is below DEPTH and is not the
    // hardwired zero register. Everything else reads 0 and ignores updates.
    function automatic logic addrOk(input logic [ADDR_SIZE-1:0] a);
        logic inRange;
        logic isZero;
        inRange = ({1'b0, a} < DEPTH_L);
        isZero  = ZERO_REG && (a == '0);
        return inRange && !isZero;
    endfunction

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wrPort
        assign w_wrAddr[j]  = wa[j*ADDR_SIZE +: ADDR_SIZE];
        assign w_wrData[j]  = wd[j*WIDTH +: WIDTH];
        assign w_wrValid[j] = we[j] && addrOk(w_wrAddr[j]);
    end

    assign w_allocValid = alloc_en && addrOk(alloc_addr);

    // Dropped writes (register 0, out of range) never count as collisions.
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (w_wrValid[j] && w_wrValid[k] && (w_wrAddr[j] == w_wrAddr[k])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Storage and scoreboard. Later write ports are applied after earlier ones
    // so the highest index wins on a collision; the alloc update comes last so
    // a newly issued producer overrides a retiring one on the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
            r_busy       <= '0;
            r_wrConflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wrValid[j]) begin
                    r_regs[w_wrAddr[j]] <= w_wrData[j];
                    r_busy[w_wrAddr[j]] <= 1'b0;
                end
            end
            if (w_allocValid) begin
                r_busy[alloc_addr] <= 1'b1;
            end
            r_wrConflict <= w_conflict;
        end
    end

    assign wr_conflict = r_wrConflict;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rdPort
        logic [ADDR_SIZE-1:0] w_addr;
        logic                 w_ok;
        logic                 w_hit;
        logic [WIDTH-1:0]     w_bypData;
        logic                 w_allocHit;

        assign w_addr     = ra[i*ADDR_SIZE +: ADDR_SIZE];
        assign w_ok       = addrOk(w_addr);
        assign w_allocHit = w_allocValid && (alloc_addr == w_addr);

        // Scan write ports in ascending order so the last match is the same
        // port that wins the storage update.
        always_comb begin
            w_hit     = 1'b0;
            w_bypData = '0;
            if (BYPASS) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wrValid[j] && (w_wrAddr[j] == w_addr)) begin
                        w_hit     = 1'b1;
                        w_bypData = w_wrData[j];
                    end
                end
            end
        end

        // A forwarded write also retires the producer, unless a new producer
        // is being allocated to the same register in this very cycle.
        always_comb begin
            rd[i*WIDTH +: WIDTH] = '0;
            rd_busy[i]           = 1'b0;
            if (w_ok) begin
                rd[i*WIDTH +: WIDTH] = r_regs[w_addr];
                rd_busy[i]           = r_busy[w_addr];
            end
            if (w_hit) begin
                rd[i*WIDTH +: WIDTH] = w_bypData;
                if (!w_allocHit) begin
                    rd_busy[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
//   Bench for regfile_mp. Three instances share one stimulus stream:
//     dutA  default build (bypass on, zero register on, DEPTH 32)
//     dutB  BYPASS=0
//     dutC  DEPTH=20
//   The stimulus thread pushes expected values into a queue and raises a
//   sample strobe; an independent monitor pops the queue on each strobe and
//   compares against the selected instance output.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int W  = 16;
    localparam int AS = 5;

    localparam int SEL_RD_A   = 0;
    localparam int SEL_BUSY_A = 1;
    localparam int SEL_CONF_A = 2;
    localparam int SEL_RD_B   = 3;
    localparam int SEL_BUSY_B = 4;
    localparam int SEL_RD_C   = 5;
    localparam int SEL_BUSY_C = 6;
    localparam int SEL_CONF_C = 7;
    localparam int SEL_CONF_B = 8;

    logic            clk;
    logic            rst;
    logic [3*AS-1:0] ra;
    logic [2*AS-1:0] wa;
    logic [2*W-1:0]  wd;
    logic [1:0]      we;
    logic            allocEn;
    logic [AS-1:0]   allocAddr;

    logic [3*W-1:0]  rdA, rdB, rdC;
    logic [2:0]      rdBusyA, rdBusyB, rdBusyC;
    logic            wrConfA, wrConfB, wrConfC;

    logic            sampleStb;
    int              checkCount;
    int              passCount;

    typedef struct {
        string       name;
        int          sel;
        logic [47:0] exp;
    } expT;

    expT sbQ[$];

    regfile_mp dutA (
        .clk(clk), .rst(rst), .ra(ra), .rd(rdA), .rd_busy(rdBusyA),
        .wa(wa), .wd(wd), .we(we), .alloc_en(allocEn), .alloc_addr(allocAddr),
        .wr_conflict(wrConfA)
    );

    regfile_mp #(.BYPASS(1'b0)) dutB (
        .clk(clk), .rst(rst), .ra(ra), .rd(rdB), .rd_busy(rdBusyB),
        .wa(wa), .wd(wd), .we(we), .alloc_en(allocEn), .alloc_addr(allocAddr),
        .wr_conflict(wrConfB)
    );

    regfile_mp #(.DEPTH(20)) dutC (
        .clk(clk), .rst(rst), .ra(ra), .rd(rdC), .rd_busy(rdBusyC),
        .wa(wa), .wd(wd), .we(we), .alloc_en(allocEn), .alloc_addr(allocAddr),
        .wr_conflict(wrConfC)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every strobe drains the queue and compares each entry against
    // the instance output it names.
    initial begin
        expT         e;
        logic [47:0] act;
        checkCount = 0;
        passCount  = 0;
        forever begin
            @(posedge sampleStb);
            while (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                case (e.sel)
                    SEL_RD_A:   act = rdA;
                    SEL_BUSY_A: act = {45'd0, rdBusyA};
                    SEL_CONF_A: act = {47'd0, wrConfA};
                    SEL_RD_B:   act = rdB;
                    SEL_BUSY_B: act = {45'd0, rdBusyB};
                    SEL_CONF_B: act = {47'd0, wrConfB};
                    SEL_RD_C:   act = rdC;
                    SEL_BUSY_C: act = {45'd0, rdBusyC};
                    SEL_CONF_C: act = {47'd0, wrConfC};
                    default:    act = 'x;
                endcase
                checkCount++;
                if (act === e.exp) begin
                    passCount++;
                end else begin
                    $display("[TB] FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic [AS-1:0] ra0, input logic [AS-1:0] ra1, input logic [AS-1:0] ra2,
        input logic [1:0]    weV,
        input logic [AS-1:0] wa0, input logic [W-1:0] wd0,
        input logic [AS-1:0] wa1, input logic [W-1:0] wd1,
        input logic          aEn, input logic [AS-1:0] aAddr
    );
        ra        = {ra2, ra1, ra0};
        we        = weV;
        wa        = {wa1, wa0};
        wd        = {wd1, wd0};
        allocEn   = aEn;
        allocAddr = aAddr;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [47:0] exp);
        expT e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    // Strobe lands mid-cycle, well away from the rising edge.
    task automatic sampleNow();
        #2;
        sampleStb = 1'b1;
        #1;
        sampleStb = 1'b0;
    endtask

    initial begin
        sampleStb = 1'b0;
        rst       = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Preload 5 and 9 with BEEF, make 12 busy.
        applyStimulus(0, 0, 0, 2'b11, 5, 16'hBEEF, 9, 16'hBEEF, 1'b1, 12);

        // Colliding write to 7, port 1 must win and be forwarded.
        tick();
        applyStimulus(7, 5, 12, 2'b11, 7, 16'h1111, 7, 16'h2222, 1'b0, 0);
        checkOutput("collide_bypass_rdA", SEL_RD_A,   48'h0000_BEEF_2222);
        checkOutput("collide_nobyp_rdB",  SEL_RD_B,   48'h0000_BEEF_0000);
        checkOutput("alloc12_busyA",      SEL_BUSY_A, 48'h4);
        checkOutput("noconf_yet_A",       SEL_CONF_A, 48'h0);
        sampleNow();

        // Pulse visible, then asynchronous reset mid-cycle clears everything.
        tick();
        applyStimulus(7, 5, 12, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("conf_pulse_A",   SEL_CONF_A, 48'h1);
        checkOutput("preload_rdA",    SEL_RD_A,   48'h0000_BEEF_2222);
        checkOutput("preload_rdB",    SEL_RD_B,   48'h0000_BEEF_2222);
        checkOutput("preload_busyA",  SEL_BUSY_A, 48'h4);
        sampleNow();
        rst = 1'b0;
        checkOutput("rst_rdA",   SEL_RD_A,   48'h0);
        checkOutput("rst_busyA", SEL_BUSY_A, 48'h0);
        checkOutput("rst_confA", SEL_CONF_A, 48'h0);
        checkOutput("rst_rdB",   SEL_RD_B,   48'h0);
        sampleNow();
        tick();
        rst = 1'b1;

        // Two-port write to 5 and 9.
        tick();
        applyStimulus(0, 0, 0, 2'b11, 5, 16'h1234, 9, 16'hABCD, 1'b0, 0);

        // Read back; a write to register 0 is dropped even when forwarded.
        tick();
        applyStimulus(5, 9, 0, 2'b01, 0, 16'hFFFF, 0, 0, 1'b0, 0);
        checkOutput("wr59_rdA",  SEL_RD_A,   48'h0000_ABCD_1234);
        checkOutput("wr59_rdB",  SEL_RD_B,   48'h0000_ABCD_1234);
        checkOutput("wr59_conf", SEL_CONF_A, 48'h0);
        sampleNow();

        // Both ports write register 0: no conflict, still reads 0.
        tick();
        applyStimulus(0, 0, 0, 2'b11, 0, 16'h5555, 0, 16'h6666, 1'b0, 0);
        checkOutput("zero_rdA", SEL_RD_A, 48'h0);
        checkOutput("zero_rdB", SEL_RD_B, 48'h0);
        sampleNow();

        // Bypass of write to 3 on read port 1.
        tick();
        applyStimulus(0, 3, 0, 2'b01, 3, 16'h00A5, 0, 0, 1'b0, 0);
        checkOutput("zero_noconf_A", SEL_CONF_A, 48'h0);
        checkOutput("byp3_rdA",      SEL_RD_A,   48'h0000_00A5_0000);
        checkOutput("byp3_old_rdB",  SEL_RD_B,   48'h0);
        sampleNow();

        // Without bypass the value appears the cycle after; alloc 12.
        tick();
        applyStimulus(12, 3, 0, 2'b00, 0, 0, 0, 0, 1'b1, 12);
        checkOutput("byp3_next_rdB", SEL_RD_B,   48'h0000_00A5_0000);
        checkOutput("alloc_cycle_A", SEL_BUSY_A, 48'h0);
        sampleNow();

        tick();
        applyStimulus(12, 3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("busy12_A", SEL_BUSY_A, 48'h1);
        checkOutput("busy12_B", SEL_BUSY_B, 48'h1);
        sampleNow();

        // Retire 12: forwarded clear on A, still busy on B this cycle.
        tick();
        applyStimulus(12, 3, 0, 2'b01, 12, 16'h0C0C, 0, 0, 1'b0, 0);
        checkOutput("retire12_busyA", SEL_BUSY_A, 48'h0);
        checkOutput("retire12_busyB", SEL_BUSY_B, 48'h1);
        checkOutput("retire12_rdA",   SEL_RD_A,   48'h0000_00A5_0C0C);
        sampleNow();

        tick();
        applyStimulus(12, 3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("after_retire_busyA", SEL_BUSY_A, 48'h0);
        checkOutput("after_retire_busyB", SEL_BUSY_B, 48'h0);
        checkOutput("after_retire_rdB",   SEL_RD_B,   48'h0000_00A5_0C0C);
        sampleNow();

        // Alloc and write 12 together: new producer wins.
        tick();
        applyStimulus(12, 3, 0, 2'b01, 12, 16'h0D0D, 0, 0, 1'b1, 12);
        checkOutput("allocwr_same_busyA", SEL_BUSY_A, 48'h0);
        sampleNow();

        // Alloc of register 0 must be ignored.
        tick();
        applyStimulus(12, 0, 0, 2'b00, 0, 0, 0, 0, 1'b1, 0);
        checkOutput("allocwr_after_busyA", SEL_BUSY_A, 48'h1);
        checkOutput("allocwr_after_busyB", SEL_BUSY_B, 48'h1);
        checkOutput("allocwr_after_rdA",   SEL_RD_A,   48'h0000_0000_0D0D);
        sampleNow();

        // Address 25: valid on A, out of range on C.
        tick();
        applyStimulus(12, 0, 25, 2'b01, 25, 16'h7777, 0, 0, 1'b1, 25);
        checkOutput("a25_busyA", SEL_BUSY_A, 48'h1);
        checkOutput("a25_rdA",   SEL_RD_A,   48'h7777_0000_0D0D);
        checkOutput("a25_rdC",   SEL_RD_C,   48'h0000_0000_0D0D);
        checkOutput("a25_busyC", SEL_BUSY_C, 48'h1);
        sampleNow();

        tick();
        applyStimulus(5, 3, 25, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("r25_rdA",   SEL_RD_A,   48'h7777_00A5_1234);
        checkOutput("r25_busyA", SEL_BUSY_A, 48'h4);
        checkOutput("r25_rdC",   SEL_RD_C,   48'h0000_00A5_1234);
        checkOutput("r25_busyC", SEL_BUSY_C, 48'h0);
        sampleNow();

        // Second collision, then confirm the pulse lasts one cycle.
        tick();
        applyStimulus(9, 12, 19, 2'b11, 7, 16'h1111, 7, 16'h2222, 1'b0, 0);
        checkOutput("c_unchanged_rdC", SEL_RD_C, 48'h0000_0D0D_ABCD);
        sampleNow();

        tick();
        applyStimulus(7, 12, 19, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("conf2_A",   SEL_CONF_A, 48'h1);
        checkOutput("conf2_B",   SEL_CONF_B, 48'h1);
        checkOutput("conf2_C",   SEL_CONF_C, 48'h1);
        checkOutput("conf2_rdA", SEL_RD_A,   48'h0000_0D0D_2222);
        sampleNow();

        tick();
        checkOutput("conf2_drop_A", SEL_CONF_A, 48'h0);
        sampleNow();

        #2;
        checkCount++;
        if (sbQ.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Next-generation register file: parametrised width/depth, NUM_RD asynchronous read ports, NUM_WR synchronous write ports.
- Adds optional write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard for pipelined/multi-cycle producers.
- Sits between decode (reads, alloc) and writeback (writes) of the CPU datapath.

Parameters:
- WIDTH, 16, data width per register
- DEPTH, 32, number of registers
- ADDR_SIZE, $clog2(DEPTH), address width
- NUM_RD, 3, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- ra  input  NUM_RD*ADDR_SIZE  read addresses; port i at bits [i*ADDR_SIZE +: ADDR_SIZE]
- rd  output  NUM_RD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  output  NUM_RD  busy flag of register addressed by read port i
- wa  input  NUM_WR*ADDR_SIZE  write addresses
- wd  input  NUM_WR*WIDTH  write data
- we  input  NUM_WR  write enables
- alloc_en  input  1  mark alloc_addr busy (producer issued)
- alloc_addr  input  ADDR_SIZE  register to mark busy
- wr_conflict  output  1  registered pulse: two or more enabled write ports hit the same address last cycle

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, wr_conflict 0. Writes/allocs asserted during reset are ignored. Reset deassertion takes effect from the next rising edge.
- Write: on posedge, for each port with we[j]=1, reg[wa[j]] <= wd[j].
  - Same address on multiple enabled ports: highest-index port wins.
  - wr_conflict <= 1 for exactly one cycle after such a collision, else 0.
- Read: combinational, zero latency.
  - rd[i] = reg[ra[i]].
  - If BYPASS=1 and any enabled write port targets ra[i] this cycle, rd[i] = winning port's wd instead.
- ZERO_REG=1 behaviour for address 0:
  - rd = 0 and rd_busy = 0, including under bypass.
  - Writes are dropped and do not count as conflicts.
  - alloc is ignored.
- Addresses >= DEPTH (non-power-of-two DEPTH): read 0, rd_busy 0; writes and alloc ignored.
- Scoreboard:
  - Posedge with alloc_en=1: busy[alloc_addr] <= 1.
  - Posedge with an enabled write to address A: busy[A] <= 0.
  - Alloc and write to the same address in the same cycle: busy ends at 1 (new producer wins over retiring one).
- rd_busy[i] = busy[ra[i]], except when BYPASS=1 and a write to ra[i] occurs this cycle without a same-cycle alloc to it; then rd_busy[i] = 0.
- Without bypass, a read the cycle after a write returns the new value.

Test Plan:
- Reset with registers preloaded to 0xBEEF, rst=0 mid-cycle -> all rd=0x0000, rd_busy=0, wr_conflict=0 immediately, not at the next edge.
- Write port0 addr5=0x1234, port1 addr9=0xABCD in one cycle; next cycle ra={5,9,0} -> rd={0x1234,0xABCD,0x0000}. Write addr0=0xFFFF -> reads 0.
- Same cycle: we=2'b11, wa={7,7}, wd0=0x1111, wd1=0x2222 -> reg7=0x2222, wr_conflict=1 for one cycle, then 0. With BYPASS=1, ra0=7 that cycle -> rd0=0x2222.
- Bypass: write addr3=0x00A5 while ra1=3 -> rd1=0x00A5 same cycle. Repeat with BYPASS=0 -> old value, then 0x00A5 next cycle.
- Scoreboard:
  - alloc addr12 -> rd_busy=1 on port reading 12 next cycle.
  - Write addr12 -> rd_busy=0 in the write cycle (bypass) and after.
  - alloc+write addr12 in the same cycle -> busy stays 1.
- DEPTH=20 build: write/alloc addr25 ignored; read addr25 -> rd=0, rd_busy=0; registers 0..19 unchanged.
